// File: rtl/mem_bus_arbiter.sv
// Two-master, single-outstanding memory bus arbiter with response routing and a response watchdog.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise m1 (debug) has fixed priority.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dbg_halted_i,

  input  logic              m0_req_valid_i,
  output logic              m0_req_ready_o,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic [3:0]        m0_wen_i,
  output logic              m0_rsp_valid_o,
  input  logic              m0_rsp_ready_i,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_err_o,

  input  logic              m1_req_valid_i,
  output logic              m1_req_ready_o,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  input  logic [3:0]        m1_wen_i,
  output logic              m1_rsp_valid_o,
  input  logic              m1_rsp_ready_i,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_err_o,

  output logic              s_req_valid_o,
  input  logic              s_req_ready_i,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_wdata_o,
  output logic [3:0]        s_wen_o,
  input  logic              s_rsp_valid_i,
  output logic              s_rsp_ready_o,
  input  logic [DATA_W-1:0] s_rdata_i,

  output logic [7:0]        timeout_cnt_o
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RSP = 2'd1,
    ERR_RSP  = 2'd2,
    DRAIN    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic [7:0]  wdog_q, wdog_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        drained_q, drained_d;

  logic        elig0, elig1;
  logic        win_vld, win;
  logic        req_hs;

  logic        rsp_valid;
  logic        rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic        owner_rsp_ready;

  assign elig0   = m0_req_valid_i & ~dbg_halted_i;
  assign elig1   = m1_req_valid_i;
  assign win_vld = elig0 | elig1;

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;

  // On a tie the master not granted last time wins.
  always_comb begin
    win = elig1;
    if (elig0 && elig1) begin
      win = ~last_q;
    end
  end

  always_comb begin
    last_d = last_q;
    if (req_hs) begin
      last_d = win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    win = elig1;
  end
`endif

  assign req_hs          = (state_q == IDLE) & win_vld & s_req_ready_i;
  assign owner_rsp_ready = owner_q ? m1_rsp_ready_i : m0_rsp_ready_i;

  // Request path: winner's fields drive the slave only while idle.
  always_comb begin
    s_req_valid_o  = 1'b0;
    s_addr_o       = '0;
    s_wdata_o      = '0;
    s_wen_o        = '0;
    m0_req_ready_o = 1'b0;
    m1_req_ready_o = 1'b0;
    if (rst_n && state_q == IDLE && win_vld) begin
      s_req_valid_o  = 1'b1;
      s_addr_o       = win ? m1_addr_i  : m0_addr_i;
      s_wdata_o      = win ? m1_wdata_i : m0_wdata_i;
      s_wen_o        = win ? m1_wen_i   : m0_wen_i;
      m0_req_ready_o = ~win & s_req_ready_i;
      m1_req_ready_o =  win & s_req_ready_i;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    wdog_d        = wdog_q;
    tcnt_d        = tcnt_q;
    drained_d     = drained_q;
    rsp_valid     = 1'b0;
    rsp_err       = 1'b0;
    rsp_rdata     = '0;
    s_rsp_ready_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_hs) begin
          owner_d   = win;
          wdog_d    = '0;
          drained_d = 1'b0;
          state_d   = WAIT_RSP;
        end
      end

      WAIT_RSP: begin
        rsp_valid     = s_rsp_valid_i;
        rsp_rdata     = s_rdata_i;
        s_rsp_ready_o = owner_rsp_ready;
        // A handshake in the same cycle the watchdog expires still wins.
        if (s_rsp_valid_i && owner_rsp_ready) begin
          state_d = IDLE;
        end else if (wdog_q == TO_LIMIT) begin
          state_d = ERR_RSP;
          tcnt_d  = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end

      ERR_RSP: begin
        rsp_valid     = 1'b1;
        rsp_err       = 1'b1;
        s_rsp_ready_o = 1'b1;
        if (s_rsp_valid_i) begin
          drained_d = 1'b1;
        end
        if (owner_rsp_ready) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        // Swallow one late slave response so it never reaches the next owner.
        if (drained_q) begin
          drained_d = 1'b0;
          state_d   = IDLE;
        end else begin
          s_rsp_ready_o = 1'b1;
          if (s_rsp_valid_i) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (!rst_n) begin
      s_rsp_ready_o = 1'b0;
      rsp_valid     = 1'b0;
      rsp_err       = 1'b0;
      rsp_rdata     = '0;
    end
  end

  // Response demux to the owning master.
  always_comb begin
    m0_rsp_valid_o = rsp_valid & ~owner_q;
    m1_rsp_valid_o = rsp_valid &  owner_q;
    m0_err_o       = rsp_err   & ~owner_q;
    m1_err_o       = rsp_err   &  owner_q;
    m0_rdata_o     = owner_q ? '0 : rsp_rdata;
    m1_rdata_o     = owner_q ? rsp_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      wdog_q    <= '0;
      tcnt_q    <= '0;
      drained_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      wdog_q    <= wdog_d;
      tcnt_q    <= tcnt_d;
      drained_q <= drained_d;
    end
  end

  assign timeout_cnt_o = tcnt_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, directed corner sequences,
// and randomized transactions against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int TO = 8;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dbg_halted_i;
  logic        m0_req_valid_i, m0_req_ready_o, m0_rsp_valid_o, m0_rsp_ready_i, m0_err_o;
  logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
  logic [3:0]  m0_wen_i;
  logic        m1_req_valid_i, m1_req_ready_o, m1_rsp_valid_o, m1_rsp_ready_i, m1_err_o;
  logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
  logic [3:0]  m1_wen_i;
  logic        s_req_valid_o, s_req_ready_i, s_rsp_valid_i, s_rsp_ready_o;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
  logic [3:0]  s_wen_o;
  logic [7:0]  timeout_cnt_o;

  int checks = 0;
  int errors = 0;
  bit model_last;
  logic [7:0] exp_tcnt;
  int last_winner;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .dbg_halted_i(dbg_halted_i),
    .m0_req_valid_i(m0_req_valid_i), .m0_req_ready_o(m0_req_ready_o),
    .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_wen_i(m0_wen_i),
    .m0_rsp_valid_o(m0_rsp_valid_o), .m0_rsp_ready_i(m0_rsp_ready_i),
    .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_valid_i(m1_req_valid_i), .m1_req_ready_o(m1_req_ready_o),
    .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_wen_i(m1_wen_i),
    .m1_rsp_valid_o(m1_rsp_valid_o), .m1_rsp_ready_i(m1_rsp_ready_i),
    .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .s_req_valid_o(s_req_valid_o), .s_req_ready_i(s_req_ready_i),
    .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_wen_o(s_wen_o),
    .s_rsp_valid_i(s_rsp_valid_i), .s_rsp_ready_o(s_rsp_ready_o),
    .s_rdata_i(s_rdata_i), .timeout_cnt_o(timeout_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    dbg_halted_i = 0; s_req_ready_i = 0; s_rsp_valid_i = 0; s_rdata_i = 0;
    m0_req_valid_i = 0; m0_addr_i = 0; m0_wdata_i = 0; m0_wen_i = 0; m0_rsp_ready_i = 0;
    m1_req_valid_i = 0; m1_addr_i = 0; m1_wdata_i = 0; m1_wen_i = 0; m1_rsp_ready_i = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    model_last = 0;
    exp_tcnt = 0;
  endtask

  // Arbitration rule: halt masks m0; tie goes to m1 (fixed) or to the master not granted last (RR).
  function automatic int pick(input bit v0, input bit v1, input bit halt);
    bit e0;
    e0 = v0 && !halt;
    if (e0 && v1) return RR ? (model_last ? 0 : 1) : 1;
    if (v1) return 1;
    if (e0) return 0;
    return -1;
  endfunction

  // One complete transaction. lat = idle WAIT cycles before the slave answers;
  // lat > TO means the watchdog aborts. late_in_err puts the stale response in ERR_RSP.
  task automatic run_txn(input bit v0, input bit v1, input bit halt,
                         input logic [3:0] w0, input logic [3:0] w1,
                         input int lat, input bit late_in_err, input logic [31:0] rd);
    int w;
    bit done;
    logic [31:0] ea, ed;
    logic [3:0] ew;
    logic ov, oe, oth;
    logic [31:0] ordat;
    m0_req_valid_i = v0; m1_req_valid_i = v1; dbg_halted_i = halt;
    m0_addr_i = $urandom; m0_wdata_i = $urandom; m0_wen_i = w0;
    m1_addr_i = $urandom; m1_wdata_i = $urandom; m1_wen_i = w1;
    s_req_ready_i = 1; s_rsp_valid_i = 0;
    m0_rsp_ready_i = 1; m1_rsp_ready_i = 1;
    w = pick(v0, v1, halt);
    last_winner = w;
    @(negedge clk);
    chk("s_req_valid", s_req_valid_o, w >= 0);
    if (w < 0) begin
      chk("no_grant_ready", {m0_req_ready_o, m1_req_ready_o}, 2'b00);
      tick();
      m0_req_valid_i = 0; m1_req_valid_i = 0;
      return;
    end
    ea = w ? m1_addr_i : m0_addr_i;
    ed = w ? m1_wdata_i : m0_wdata_i;
    ew = w ? m1_wen_i : m0_wen_i;
    chk("req_ready", {m1_req_ready_o, m0_req_ready_o}, (w == 1) ? 2'b10 : 2'b01);
    chk("s_addr", s_addr_o, ea);
    chk("s_wdata", s_wdata_o, ed);
    chk("s_wen", s_wen_o, ew);
    tick();
    model_last = w[0];
    m0_req_valid_i = 0; m1_req_valid_i = 0; dbg_halted_i = 0;
    done = 0;
    for (int k = 0; k <= TO && !done; k++) begin
      s_rsp_valid_i = (k == lat);
      s_rdata_i = (k == lat) ? rd : $urandom;
      @(negedge clk);
      ov = w ? m1_rsp_valid_o : m0_rsp_valid_o;
      oth = w ? m0_rsp_valid_o : m1_rsp_valid_o;
      oe = w ? m1_err_o : m0_err_o;
      ordat = w ? m1_rdata_o : m0_rdata_o;
      chk("owner_rsp_valid", ov, k == lat);
      chk("other_rsp_valid", oth, 1'b0);
      chk("s_rsp_ready", s_rsp_ready_o, 1'b1);
      if (k == lat) begin
        chk("rdata", ordat, rd);
        chk("err_ok", oe, 1'b0);
        chk("tcnt_ok", timeout_cnt_o, exp_tcnt);
        done = 1;
      end
      tick();
    end
    s_rsp_valid_i = 0;
    if (!done) begin
      exp_tcnt = (exp_tcnt == 8'hFF) ? exp_tcnt : exp_tcnt + 8'd1;
      s_rsp_valid_i = late_in_err;
      s_rdata_i = $urandom;
      @(negedge clk);
      ov = w ? m1_rsp_valid_o : m0_rsp_valid_o;
      oth = w ? m0_rsp_valid_o : m1_rsp_valid_o;
      oe = w ? m1_err_o : m0_err_o;
      ordat = w ? m1_rdata_o : m0_rdata_o;
      chk("abort_valid", ov, 1'b1);
      chk("abort_err", oe, 1'b1);
      chk("abort_rdata", ordat, 32'h0);
      chk("abort_other", oth, 1'b0);
      chk("abort_tcnt", timeout_cnt_o, exp_tcnt);
      chk("abort_s_rsp_ready", s_rsp_ready_o, 1'b1);
      tick();
      s_rsp_valid_i = !late_in_err;
      s_rdata_i = 32'hBAD0_BAD0;
      @(negedge clk);
      chk("drain_m0_valid", m0_rsp_valid_o, 1'b0);
      chk("drain_m1_valid", m1_rsp_valid_o, 1'b0);
      if (!late_in_err) chk("drain_s_rsp_ready", s_rsp_ready_o, 1'b1);
      tick();
      s_rsp_valid_i = 0;
    end
  endtask

  typedef struct {
    bit v0, v1, halt, sready;
    bit exp_sv, exp_r0, exp_r1, exp_sel1;
  } vec_t;

  vec_t vecs[8];
  int exp_tie[4];

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0] = '{0, 0, 0, 1, 0, 0, 0, 0};
    vecs[1] = '{1, 0, 0, 0, 1, 0, 0, 0};
    vecs[2] = '{0, 1, 0, 0, 1, 0, 0, 1};
    vecs[3] = '{1, 1, 0, 0, 1, 0, 0, 1};
    vecs[4] = '{1, 0, 1, 1, 0, 0, 0, 0};
    vecs[5] = '{1, 1, 1, 0, 1, 0, 0, 1};
    vecs[6] = '{0, 0, 1, 1, 0, 0, 0, 0};
    vecs[7] = '{0, 1, 1, 0, 1, 0, 0, 1};

    do_reset();
    @(negedge clk);
    chk("rst_s_req_valid", s_req_valid_o, 1'b0);
    chk("rst_req_ready", {m0_req_ready_o, m1_req_ready_o}, 2'b00);
    chk("rst_rsp_valid", {m0_rsp_valid_o, m1_rsp_valid_o}, 2'b00);
    chk("rst_err", {m0_err_o, m1_err_o}, 2'b00);
    chk("rst_rdata", {m0_rdata_o, m1_rdata_o}, 64'h0);
    chk("rst_s_rsp_ready", s_rsp_ready_o, 1'b0);
    chk("rst_tcnt", timeout_cnt_o, 8'h0);
    tick();

    // Combinational arbitration vectors; none of these completes a handshake.
    m0_addr_i = 32'h0000_00A0; m1_addr_i = 32'h0000_00B1;
    for (int i = 0; i < 8; i++) begin
      m0_req_valid_i = vecs[i].v0; m1_req_valid_i = vecs[i].v1;
      dbg_halted_i = vecs[i].halt; s_req_ready_i = vecs[i].sready;
      @(negedge clk);
      chk($sformatf("vec%0d_s_req_valid", i), s_req_valid_o, vecs[i].exp_sv);
      chk($sformatf("vec%0d_m0_ready", i), m0_req_ready_o, vecs[i].exp_r0);
      chk($sformatf("vec%0d_m1_ready", i), m1_req_ready_o, vecs[i].exp_r1);
      if (vecs[i].exp_sv)
        chk($sformatf("vec%0d_s_addr", i), s_addr_o, vecs[i].exp_sel1 ? 32'hB1 : 32'hA0);
      tick();
    end
    clear_inputs();

    // m0 read, slave answers after 3 cycles.
    do_reset();
    run_txn(1, 0, 0, 4'b0000, 4'b0000, 3, 0, 32'hDEADBEEF);
    chk("m0_read_winner", last_winner, 0);

    // Four back-to-back ties.
    if (RR) begin exp_tie[0] = 1; exp_tie[1] = 0; exp_tie[2] = 1; exp_tie[3] = 0; end
    else    begin exp_tie[0] = 1; exp_tie[1] = 1; exp_tie[2] = 1; exp_tie[3] = 1; end
    for (int i = 0; i < 4; i++) begin
      run_txn(1, 1, 0, 4'b0000, 4'b0000, 0, 0, $urandom);
      chk($sformatf("tie%0d_winner", i), last_winner, exp_tie[i]);
    end

    // Halt masks m0; dropping halt grants in that same cycle.
    do_reset();
    m0_req_valid_i = 1; dbg_halted_i = 1; s_req_ready_i = 1; m0_addr_i = 32'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("halt_s_req_valid", s_req_valid_o, 1'b0);
      chk("halt_m0_ready", m0_req_ready_o, 1'b0);
      tick();
    end
    run_txn(1, 0, 0, 4'b0000, 4'b0000, 1, 0, 32'h0BAD_F00D);

    // Slave never answers: abort, stale response drained, then m1 gets its own data.
    run_txn(1, 0, 0, 4'b0000, 4'b0000, TO + 5, 0, 32'hFFFF_FFFF);
    chk("timeout_cnt_after_abort", timeout_cnt_o, 8'd1);
    run_txn(0, 1, 0, 4'b0000, 4'b0000, 1, 0, 32'h1234_5678);
    run_txn(0, 1, 0, 4'b0000, 4'b0000, TO + 1, 1, 32'h0);
    chk("timeout_cnt_after_abort2", timeout_cnt_o, 8'd2);

    // Handshake on the exact watchdog-expiry cycle is a normal response.
    run_txn(1, 0, 0, 4'b0000, 4'b0000, TO, 0, 32'hCAFE_0001);
    chk("boundary_tcnt", timeout_cnt_o, 8'd2);

    // Reset while a response is pending.
    m0_req_valid_i = 1; m0_addr_i = 32'h80; s_req_ready_i = 1;
    tick();
    m0_req_valid_i = 0;
    s_rsp_valid_i = 1; s_rdata_i = 32'h5555_AAAA; m0_rsp_ready_i = 0;
    @(negedge clk);
    chk("pre_rst_m0_rsp_valid", m0_rsp_valid_o, 1'b1);
    m0_req_valid_i = 1;
    #2 rst_n = 0;
    #1;
    chk("mid_rst_rsp_valid", {m0_rsp_valid_o, m1_rsp_valid_o}, 2'b00);
    chk("mid_rst_s_rsp_ready", s_rsp_ready_o, 1'b0);
    chk("mid_rst_rdata", m0_rdata_o, 32'h0);
    chk("mid_rst_s_req_valid", s_req_valid_o, 1'b0);
    chk("mid_rst_tcnt", timeout_cnt_o, 8'h0);
    do_reset();
    run_txn(1, 0, 0, 4'b0011, 4'b0000, 2, 0, 32'h0);

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      run_txn($urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
              4'($urandom), 4'($urandom), $urandom_range(0, TO + 3),
              $urandom_range(0, 1), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
